// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: FSM encoding and channel-index width helper.
package wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RD,
    S_LAT,
    S_WR,
    S_DONE
  } state_e;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_next_channel.sv
// Combinational search for the next masked-in channel strictly above i_cur.
// When none is left in the current word it wraps to the lowest masked-in channel.
module wb_next_channel #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  output logic [CH_W-1:0]   o_next,
  output logic              o_wrap,
  output logic              o_any
);

  logic found_above;
  logic found_low;
  logic [CH_W-1:0] next_above;
  logic [CH_W-1:0] next_low;

  // Lowest set bit above i_cur, and lowest set bit overall for the wrap case.
  always_comb begin
    found_above = 1'b0;
    found_low   = 1'b0;
    next_above  = '0;
    next_low    = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!found_above && i_mask[j] && (j > int'(i_cur))) begin
        found_above = 1'b1;
        next_above  = CH_W'(j);
      end
      if (!found_low && i_mask[j]) begin
        found_low = 1'b1;
        next_low  = CH_W'(j);
      end
    end
    o_any  = found_low;
    o_wrap = !found_above;
    o_next = found_above ? next_above : next_low;
  end

endmodule

// File: rtl/write_back_sequencer.sv
// Write-back engine: drains NUM_CH result RAMs into SDRAM as one word-major,
// channel-interleaved stream. Masked-out channels leave no gaps in SDRAM.
module write_back_sequencer
  import wb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 19,
  parameter int LEN_W   = 12,
  parameter int RAM_LAT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [NUM_CH*ADDR_W-1:0]   i_baseAddr,
  input  logic [ADDR_W-1:0]          i_sdramBase,
  input  logic [LEN_W-1:0]           i_length,
  input  logic [NUM_CH-1:0]          i_chMask,
  input  logic                       i_sdramReady,
  output logic [NUM_CH*ADDR_W-1:0]   o_addrToRam,
  output logic                       o_quickRam,
  output logic [ADDR_W-1:0]          o_addrToSdram,
  output logic                       o_wrSdram,
  output logic [ch_w(NUM_CH)-1:0]    o_selData,
  output logic                       o_busy,
  output logic                       o_finish
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int LAT_W = ch_w(RAM_LAT);

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [LEN_W-1:0]           k_q, k_d;
  logic [ADDR_W-1:0]          wcnt_q, wcnt_d;
  logic [LAT_W-1:0]           lat_q, lat_d;
  logic                       first_q, first_d;
  logic [NUM_CH*ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]          sdram_base_q, sdram_base_d;
  logic [LEN_W-1:0]           length_q, length_d;
  logic [NUM_CH-1:0]          mask_q, mask_d;
  logic [NUM_CH*ADDR_W-1:0]   addr_ram_q, addr_ram_d;
  logic                       quick_q, quick_d;
  logic [ADDR_W-1:0]          addr_sdram_q, addr_sdram_d;
  logic                       wr_q, wr_d;
  logic [CH_W-1:0]            sel_q, sel_d;
  logic                       busy_q, busy_d;
  logic                       finish_q, finish_d;

  logic [CH_W-1:0]            nc_next;
  logic                       nc_wrap;
  logic                       nc_any;
  logic [LEN_W-1:0]           k_step;

  wb_next_channel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next_channel (
    .i_mask (mask_q),
    .i_cur  (ch_q),
    .o_next (nc_next),
    .o_wrap (nc_wrap),
    .o_any  (nc_any)
  );

  // Next-state, counters, and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    k_d          = k_q;
    wcnt_d       = wcnt_q;
    lat_d        = lat_q;
    first_d      = first_q;
    base_d       = base_q;
    sdram_base_d = sdram_base_q;
    length_d     = length_q;
    mask_d       = mask_q;
    addr_ram_d   = addr_ram_q;
    addr_sdram_d = addr_sdram_q;
    sel_d        = sel_q;
    // A wrap advances the word, except on the very first scan where ch starts
    // parked at the top channel so that the search lands on the lowest one.
    k_step       = (nc_wrap && !first_q) ? k_q + LEN_W'(1) : k_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d       = i_baseAddr;
          sdram_base_d = i_sdramBase;
          length_d     = i_length;
          mask_d       = i_chMask;
          ch_d         = CH_W'(NUM_CH - 1);
          k_d          = '0;
          wcnt_d       = '0;
          first_d      = 1'b1;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!nc_any || (length_q == '0) || (k_step == length_q)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = nc_next;
          k_d     = k_step;
          first_d = 1'b0;
          addr_ram_d[nc_next*ADDR_W +: ADDR_W] =
            base_q[nc_next*ADDR_W +: ADDR_W] + ADDR_W'(k_step);
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (RAM_LAT > 1) begin
          lat_d   = LAT_W'(RAM_LAT - 2);
          state_d = S_LAT;
        end else begin
          state_d = S_WR;
        end
      end
      S_LAT: begin
        if (lat_q == '0) begin
          state_d = S_WR;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_WR: begin
        if (i_sdramReady) begin
          wcnt_d  = wcnt_q + ADDR_W'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    quick_d  = (state_d == S_RD);
    wr_d     = (state_d == S_WR);
    finish_d = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    if ((state_d == S_WR) && (state_q != S_WR)) begin
      sel_d        = ch_q;
      addr_sdram_d = sdram_base_q + wcnt_q;
    end
  end

  // State, job and output registers; reset aborts any job silently.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      k_q          <= '0;
      wcnt_q       <= '0;
      lat_q        <= '0;
      first_q      <= 1'b0;
      base_q       <= '0;
      sdram_base_q <= '0;
      length_q     <= '0;
      mask_q       <= '0;
      addr_ram_q   <= '0;
      quick_q      <= 1'b0;
      addr_sdram_q <= '0;
      wr_q         <= 1'b0;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      k_q          <= k_d;
      wcnt_q       <= wcnt_d;
      lat_q        <= lat_d;
      first_q      <= first_d;
      base_q       <= base_d;
      sdram_base_q <= sdram_base_d;
      length_q     <= length_d;
      mask_q       <= mask_d;
      addr_ram_q   <= addr_ram_d;
      quick_q      <= quick_d;
      addr_sdram_q <= addr_sdram_d;
      wr_q         <= wr_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
    end
  end

  assign o_addrToRam   = addr_ram_q;
  assign o_quickRam    = quick_q;
  assign o_addrToSdram = addr_sdram_q;
  assign o_wrSdram     = wr_q;
  assign o_selData     = sel_q;
  assign o_busy        = busy_q;
  assign o_finish      = finish_q;

endmodule
